// File: rtl/img2col_ctrl_if.sv
// img2col_ctrl_if: bundles the configuration, input-stream and PU-vector control
// signals of img2col_ctrl.
//   master : controller view (img2col_ctrl). It drives s_ready, the PU controls and status.
//   slave  : environment view (data mover, pus_vector, host). It drives cfg, the stream and win_ready.
interface img2col_ctrl_if #(
  parameter int unsigned data_width  = 16,
  parameter int unsigned address_num = 5
);
  logic                   cfg_start;
  logic [5:0]             cfg_rounds;
  logic                   s_valid;
  logic                   s_ready;
  logic [data_width-1:0]  s_data1;
  logic [data_width-1:0]  s_data2;
  logic [5:0]             pu_no;
  logic [5:0]             round;
  logic                   pu_start;
  logic [address_num-1:0] adrs_in1;
  logic [address_num-1:0] adrs_in2;
  logic [data_width-1:0]  new1;
  logic [data_width-1:0]  new2;
  logic                   win_valid;
  logic                   win_ready;
  logic                   busy;
  logic                   done;

  modport master (
    input  cfg_start, cfg_rounds, s_valid, s_data1, s_data2, win_ready,
    output s_ready, pu_no, round, pu_start, adrs_in1, adrs_in2, new1, new2,
           win_valid, busy, done
  );

  modport slave (
    output cfg_start, cfg_rounds, s_valid, s_data1, s_data2, win_ready,
    input  s_ready, pu_no, round, pu_start, adrs_in1, adrs_in2, new1, new2,
           win_valid, busy, done
  );
endinterface

// File: rtl/img2col_ctrl.sv
// img2col_ctrl: sequencer for the img2col PU vector.
// Each round has four phases:
//   load  : two-word beats are written into every PU register file
//   start : one compute pulse is issued to the vector
//   wait  : a fixed compute latency passes
//   drain : each PU window is handed out through a valid/ready handshake
// Rounds repeat cfg_rounds times, and a single done pulse follows the last one.
// Ports:
//   clk  : rising-edge clock
//   nrst : asynchronous active-low reset
//   ctl  : img2col_ctrl_if master modport
//          cfg_start/cfg_rounds, s_valid/s_ready/s_data1/s_data2, pu_no, round, pu_start,
//          adrs_in1/adrs_in2, new1/new2, win_valid/win_ready, busy, done
module img2col_ctrl #(
  parameter int unsigned row         = 28,
  parameter int unsigned data_width  = 16,
  parameter int unsigned address_num = 5,
  parameter int unsigned reg_num     = 20,
  parameter int unsigned compute_lat = 2
) (
  input logic          clk,
  input logic          nrst,
  img2col_ctrl_if.master ctl
);

  localparam int unsigned Beats = reg_num / 2;
  localparam int unsigned BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  // The wait counter spans the pu_start cycle plus compute_lat cycles.
  localparam int unsigned LatW  = $clog2(compute_lat + 1);

  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [5:0]       LastPu   = 6'(row - 1);
  localparam logic [LatW-1:0]  LastLat  = LatW'(compute_lat);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [BeatW-1:0]       beat_q, beat_d;
  logic [5:0]             pu_cnt_q, pu_cnt_d;  // PU being loaded; pu_no lags it by one beat
  logic [5:0]             pu_no_q, pu_no_d;
  logic [5:0]             round_q, round_d;
  logic [5:0]             rounds_q, rounds_d;
  logic [LatW-1:0]        lat_q, lat_d;
  logic [address_num-1:0] adrs1_q, adrs1_d, adrs2_q, adrs2_d;
  logic [data_width-1:0]  new1_q, new1_d, new2_q, new2_d;

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    pu_cnt_d = pu_cnt_q;
    pu_no_d  = pu_no_q;
    round_d  = round_q;
    rounds_d = rounds_q;
    lat_d    = lat_q;
    adrs1_d  = adrs1_q;
    adrs2_d  = adrs2_q;
    new1_d   = new1_q;
    new2_d   = new2_q;
    unique case (state_q)
      StIdle: begin
        if (ctl.cfg_start) begin
          rounds_d = ctl.cfg_rounds;
          round_d  = '0;
          pu_no_d  = '0;
          pu_cnt_d = '0;
          beat_d   = '0;
          state_d  = (ctl.cfg_rounds == '0) ? StDone : StLoad;
        end
      end
      StLoad: begin
        // s_ready is high for the whole state, so s_valid alone marks a handshake.
        if (ctl.s_valid) begin
          new1_d  = ctl.s_data1;
          new2_d  = ctl.s_data2;
          adrs1_d = address_num'({beat_q, 1'b0});
          adrs2_d = address_num'({beat_q, 1'b1});
          pu_no_d = pu_cnt_q;
          if (beat_q == LastBeat) begin
            beat_d = '0;
            if (pu_cnt_q == LastPu) begin
              state_d = StStart;
            end else begin
              pu_cnt_d = pu_cnt_q + 6'd1;
            end
          end else begin
            beat_d = beat_q + BeatW'(1);
          end
        end
      end
      StStart: begin
        // The last write is presented in this cycle, and the compute pulse follows it.
        lat_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == LastLat) begin
          pu_no_d = '0;
          state_d = StDrain;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StDrain: begin
        if (ctl.win_ready) begin
          if (pu_no_q == LastPu) begin
            if (round_q == rounds_q - 6'd1) begin
              state_d = StDone;
            end else begin
              round_d  = round_q + 6'd1;
              pu_no_d  = '0;
              pu_cnt_d = '0;
              beat_d   = '0;
              state_d  = StLoad;
            end
          end else begin
            pu_no_d = pu_no_q + 6'd1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= StIdle;
      beat_q   <= '0;
      pu_cnt_q <= '0;
      pu_no_q  <= '0;
      round_q  <= '0;
      rounds_q <= '0;
      lat_q    <= '0;
      adrs1_q  <= '0;
      adrs2_q  <= '0;
      new1_q   <= '0;
      new2_q   <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      pu_cnt_q <= pu_cnt_d;
      pu_no_q  <= pu_no_d;
      round_q  <= round_d;
      rounds_q <= rounds_d;
      lat_q    <= lat_d;
      adrs1_q  <= adrs1_d;
      adrs2_q  <= adrs2_d;
      new1_q   <= new1_d;
      new2_q   <= new2_d;
    end
  end

  // The strobes decode only registered state, so they never follow s_valid or win_ready.
  assign ctl.s_ready   = (state_q == StLoad);
  assign ctl.pu_start  = (state_q == StWait) && (lat_q == '0);
  assign ctl.win_valid = (state_q == StDrain);
  assign ctl.busy      = (state_q != StIdle);
  assign ctl.done      = (state_q == StDone);
  assign ctl.pu_no     = pu_no_q;
  assign ctl.round     = round_q;
  assign ctl.adrs_in1  = adrs1_q;
  assign ctl.adrs_in2  = adrs2_q;
  assign ctl.new1      = new1_q;
  assign ctl.new2      = new2_q;

endmodule
